fifo_cmd_arbiter: RTL and testbench
===================================

// Module: fifo_cmd_arbiter
// PURPOSE
//  Shares one fifo-cache command/response channel between two requesters (port 0: data-side AXI bridge, port 1: instr/DMA bridge).
//  Arbitrates cmd beats, holds write bursts atomically, and records read ownership in an in-order tag FIFO to route rsp beats back.
//  Sits between the AXI4-to-fifo bridges and the DDR fifo-cache controller; no data buffering beyond the tag FIFO.
// PARAMETERS
//  OT_DEPTH  4   max outstanding read commands (power of 2, >=2); tag FIFO depth
//  AW        27  cmd address width
//  DW        128 cmd/rsp data width; mask width = DW/8
// PORTS
//  clk                 in   1     system clock (27 MHz)
//  rst                 in   1     asynchronous reset, active-high
//  sN_cmd_valid        in   1     N=0,1: requester command valid
//  sN_cmd_ready        out  1     N=0,1: command accepted
//  sN_cmd_type         in   1     0=read, 1=write
//  sN_cmd_addr         in   AW    beat address
//  sN_cmd_burst_cnt    in   6     beats in burst; 0 encodes 64
//  sN_cmd_wt_data      in   DW    write data (write beats only)
//  sN_cmd_wt_mask      in   DW/8  write byte mask
//  sN_rsp_valid        out  1     read data beat for requester N
//  sN_rsp_ready        in   1     requester N accepts rsp beat
//  sN_rsp_data         out  DW    read data (fanout of fifo_rsp_data)
//  fifo_cmd_valid/ready/type/addr/burst_cnt/wt_data/wt_mask  out/in/out..  same widths as sN_cmd_*; muxed selected requester
//  fifo_rsp_valid      in   1     controller rsp beat
//  fifo_rsp_ready      out  1     rsp beat consumed
//  fifo_rsp_data       in   DW    controller rsp data
//  err_unexp_rsp       out  1     sticky: rsp beat arrived with tag FIFO empty
// BEHAVIOUR
//  Reset: all ready/valid outputs 0, err_unexp_rsp 0, tag FIFO empty, lock clear, rr pointer = port 0.
//  Beats = burst_cnt==0 ? 64 : burst_cnt (7-bit counters). Read = 1 cmd beat; write = Beats cmd beats, one per fifo handshake.
//  States: IDLE, HOLD (cmd presented, not yet accepted), WBURST (write beats remaining).
//  IDLE: eligible = sN_cmd_valid && (type==write || tag FIFO not full). Pick per rr pointer; grant combinational same cycle.
//   Accepted beat (fifo valid&ready): read -> push {N, Beats} to tag FIFO, rr pointer -> other port; write with Beats>1 -> WBURST, wcnt=Beats-1.
//   Selected but !fifo_cmd_ready -> HOLD: grant locked to N; no re-arbitration until accepted (AXI-style stability).
//  WBURST: grant locked to N; each accepted beat wcnt--; at wcnt==0 after last beat -> IDLE, rr pointer -> other port.
//   Requester dropping valid mid-burst just stalls; other port waits.
//  sN_cmd_ready = fifo_cmd_ready && granted==N; fifo_cmd_* = granted port's fields, valid 0 when none eligible.
//  Rsp path: head {own,rem}; fifo_rsp_ready = !empty && s[own]_rsp_ready; s[own]_rsp_valid = fifo_rsp_valid && !empty; other port 0.
//   Each rsp handshake rem--; at rem==1 pop head. Push and pop same cycle allowed (count unchanged, even when full).
//  Tag FIFO empty & fifo_rsp_valid: fifo_rsp_ready=1 (drain), err_unexp_rsp set until reset.
//  Rsp ordering: strictly in cmd-acceptance order; controller must return reads in order.
//  Reset mid-burst: abandons burst and all tags immediately; no partial recovery.
// CONFIGURATION
//  FIFO_CMD_ARB_FIXED_PRIO_EN defined: port 0 always wins in IDLE (rr pointer removed); locking unchanged.
//  Not defined: round-robin as above.
// STRUCTURE
//  Package fifo_cmd_arb_pkg: CMD_READ/CMD_WRITE consts, state enum, tag_t {owner 1b, beats 7b}, beats_f(burst_cnt) function.
//  Sub-module fifo_cmd_tag_fifo: sync FIFO of tag_t, OT_DEPTH deep, push/pop/full/empty, simultaneous push+pop.
// TESTING
//  Both ports read (burst 4) in same cycle, ready=1 -> port 0 granted first, then port 1; rsp beats 0-3 to s0, 4-7 to s1.
//  s0 write burst_cnt=3 while s1 read valid -> 3 consecutive s0 beats, s1 read granted only after 3rd beat.
//  fifo_cmd_ready=0 for 5 cycles with s0 valid, s1 raises valid -> grant stays s0, fields stable, s1_cmd_ready=0.
//  OT_DEPTH=4 reads accepted, no rsp -> 5th read blocked, write from other port still granted; first pop unblocks read.
//  burst_cnt=0 read -> exactly 64 rsp beats routed before tag popped; s0_rsp_ready low 3 cycles stalls fifo_rsp_ready.
//  fifo_rsp_valid with empty tag FIFO -> beat drained, err_unexp_rsp=1 until rst; rst mid-WBURST -> all outputs 0 next edge.

Source files
------------

// File: rtl/fifo_cmd_arb_pkg.sv
// Shared types and constants for the fifo-cache command arbiter.
// Used by fifo_cmd_arbiter and fifo_cmd_tag_fifo.
package fifo_cmd_arb_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef logic [1:0] state_t;
    localparam state_t StIdle   = 2'd0;
    localparam state_t StHold   = 2'd1;
    localparam state_t StWburst = 2'd2;

    typedef struct packed {
        logic       owner;
        logic [6:0] beats;
    } tag_t;

    // A burst count of zero encodes the maximum burst of 64 beats.
    function automatic logic [6:0] beats_f(input logic [5:0] burst_cnt);
        return (burst_cnt == 6'd0) ? 7'd64 : {1'b0, burst_cnt};
    endfunction

endpackage

// File: rtl/fifo_cmd_tag_fifo.sv
// In-order FIFO of read-ownership tags; push and pop may coincide, even when full.
module fifo_cmd_tag_fifo
    import fifo_cmd_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  tag_t wdata,
    input  logic pop,
    output tag_t rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    tag_t          mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (PW + 1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q];

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/fifo_cmd_arbiter.sv
// Two-port arbiter for the fifo-cache cmd/rsp channel with write-burst locking and read tag routing.
// Define FIFO_CMD_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module fifo_cmd_arbiter
    import fifo_cmd_arb_pkg::*;
#(
    parameter int unsigned OT_DEPTH = 4,
    parameter int unsigned AW       = 27,
    parameter int unsigned DW       = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s0_cmd_valid,
    output logic            s0_cmd_ready,
    input  logic            s0_cmd_type,
    input  logic [AW-1:0]   s0_cmd_addr,
    input  logic [5:0]      s0_cmd_burst_cnt,
    input  logic [DW-1:0]   s0_cmd_wt_data,
    input  logic [DW/8-1:0] s0_cmd_wt_mask,
    output logic            s0_rsp_valid,
    input  logic            s0_rsp_ready,
    output logic [DW-1:0]   s0_rsp_data,
    input  logic            s1_cmd_valid,
    output logic            s1_cmd_ready,
    input  logic            s1_cmd_type,
    input  logic [AW-1:0]   s1_cmd_addr,
    input  logic [5:0]      s1_cmd_burst_cnt,
    input  logic [DW-1:0]   s1_cmd_wt_data,
    input  logic [DW/8-1:0] s1_cmd_wt_mask,
    output logic            s1_rsp_valid,
    input  logic            s1_rsp_ready,
    output logic [DW-1:0]   s1_rsp_data,
    output logic            fifo_cmd_valid,
    input  logic            fifo_cmd_ready,
    output logic            fifo_cmd_type,
    output logic [AW-1:0]   fifo_cmd_addr,
    output logic [5:0]      fifo_cmd_burst_cnt,
    output logic [DW-1:0]   fifo_cmd_wt_data,
    output logic [DW/8-1:0] fifo_cmd_wt_mask,
    input  logic            fifo_rsp_valid,
    output logic            fifo_rsp_ready,
    input  logic [DW-1:0]   fifo_rsp_data,
    output logic            err_unexp_rsp
);

    state_t     state_q, state_d;
    logic       gnt_q, gnt_d;
    logic [6:0] wcnt_q, wcnt_d;
    logic [6:0] rsp_cnt_q, rsp_cnt_d;
    logic       err_q, err_d;
    logic       act, prio, sel, sel_vld, rr_flip, accept;
    logic       elig0, elig1;
    logic [6:0] sel_beats;
    logic       tag_push, tag_pop, tag_full, tag_empty, rsp_hs;
    tag_t       tag_head;

    // Outputs are forced idle while reset is held, not just after it releases.
    assign act = !rst;

    assign elig0 = s0_cmd_valid && (s0_cmd_type == CMD_WRITE || !tag_full);
    assign elig1 = s1_cmd_valid && (s1_cmd_type == CMD_WRITE || !tag_full);

`ifdef FIFO_CMD_ARB_FIXED_PRIO_EN
    assign prio = 1'b0;
`else
    logic rr_q, rr_d;

    assign prio = rr_q;
    assign rr_d = rr_flip ? ~sel : rr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_q <= 1'b0;
        else     rr_q <= rr_d;
    end
`endif

    always_comb begin
        sel     = gnt_q;
        sel_vld = 1'b0;
        unique case (state_q)
            StIdle: begin
                sel_vld = elig0 || elig1;
                sel     = (elig0 && elig1) ? prio : elig1;
            end
            StHold, StWburst: begin
                sel     = gnt_q;
                sel_vld = gnt_q ? s1_cmd_valid : s0_cmd_valid;
            end
            default: begin
                sel     = gnt_q;
                sel_vld = 1'b0;
            end
        endcase
        sel_vld = sel_vld && act;
    end

    assign fifo_cmd_valid     = sel_vld;
    assign fifo_cmd_type      = sel ? s1_cmd_type      : s0_cmd_type;
    assign fifo_cmd_addr      = sel ? s1_cmd_addr      : s0_cmd_addr;
    assign fifo_cmd_burst_cnt = sel ? s1_cmd_burst_cnt : s0_cmd_burst_cnt;
    assign fifo_cmd_wt_data   = sel ? s1_cmd_wt_data   : s0_cmd_wt_data;
    assign fifo_cmd_wt_mask   = sel ? s1_cmd_wt_mask   : s0_cmd_wt_mask;
    assign s0_cmd_ready       = fifo_cmd_ready && sel_vld && !sel;
    assign s1_cmd_ready       = fifo_cmd_ready && sel_vld && sel;

    assign accept    = sel_vld && fifo_cmd_ready;
    assign sel_beats = beats_f(fifo_cmd_burst_cnt);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        wcnt_d   = wcnt_q;
        rr_flip  = 1'b0;
        tag_push = 1'b0;
        if (accept) begin
            if (state_q == StWburst) begin
                wcnt_d = wcnt_q - 7'd1;
                if (wcnt_q == 7'd1) begin
                    state_d = StIdle;
                    rr_flip = 1'b1;
                end
            end else if (fifo_cmd_type == CMD_READ) begin
                tag_push = 1'b1;
                rr_flip  = 1'b1;
                state_d  = StIdle;
            end else if (sel_beats > 7'd1) begin
                state_d = StWburst;
                wcnt_d  = sel_beats - 7'd1;
                gnt_d   = sel;
            end else begin
                rr_flip = 1'b1;
                state_d = StIdle;
            end
        end else if (state_q == StIdle && sel_vld) begin
            state_d = StHold;
            gnt_d   = sel;
        end
    end

    fifo_cmd_tag_fifo #(
        .DEPTH(OT_DEPTH)
    ) u_tag_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (tag_push),
        .wdata(tag_t'{owner: sel, beats: sel_beats}),
        .pop  (tag_pop),
        .rdata(tag_head),
        .full (tag_full),
        .empty(tag_empty)
    );

    // With no tag outstanding, beats are drained and flagged instead of stalling the controller.
    assign fifo_rsp_ready = act && (tag_empty ? fifo_rsp_valid
                                              : (tag_head.owner ? s1_rsp_ready : s0_rsp_ready));
    assign s0_rsp_valid   = act && fifo_rsp_valid && !tag_empty && !tag_head.owner;
    assign s1_rsp_valid   = act && fifo_rsp_valid && !tag_empty && tag_head.owner;
    assign s0_rsp_data    = fifo_rsp_data;
    assign s1_rsp_data    = fifo_rsp_data;
    assign err_unexp_rsp  = err_q;

    assign rsp_hs    = fifo_rsp_valid && fifo_rsp_ready && !tag_empty;
    assign tag_pop   = rsp_hs && (rsp_cnt_q == tag_head.beats - 7'd1);
    assign rsp_cnt_d = tag_pop ? 7'd0 : (rsp_hs ? rsp_cnt_q + 7'd1 : rsp_cnt_q);
    assign err_d     = err_q || (act && tag_empty && fifo_rsp_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= 1'b0;
            wcnt_q    <= 7'd0;
            rsp_cnt_q <= 7'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            wcnt_q    <= wcnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_fifo_cmd_arbiter.sv
// Scoreboard bench for fifo_cmd_arbiter: directed stimulus, expected beats queued, monitors compare.
module tb_fifo_cmd_arbiter;
    import fifo_cmd_arb_pkg::*;

    localparam int AW = 27;
    localparam int DW = 128;
    localparam int MW = DW / 8;

    logic clk, rst;
    logic s0_cmd_valid, s0_cmd_ready, s0_cmd_type, s0_rsp_valid, s0_rsp_ready;
    logic s1_cmd_valid, s1_cmd_ready, s1_cmd_type, s1_rsp_valid, s1_rsp_ready;
    logic [AW-1:0] s0_cmd_addr, s1_cmd_addr, fifo_cmd_addr;
    logic [5:0] s0_cmd_burst_cnt, s1_cmd_burst_cnt, fifo_cmd_burst_cnt;
    logic [DW-1:0] s0_cmd_wt_data, s1_cmd_wt_data, fifo_cmd_wt_data;
    logic [MW-1:0] s0_cmd_wt_mask, s1_cmd_wt_mask, fifo_cmd_wt_mask;
    logic [DW-1:0] s0_rsp_data, s1_rsp_data, fifo_rsp_data;
    logic fifo_cmd_valid, fifo_cmd_ready, fifo_cmd_type;
    logic fifo_rsp_valid, fifo_rsp_ready, err_unexp_rsp;

    typedef struct {
        logic          port;
        logic          typ;
        logic [AW-1:0] addr;
        logic [5:0]    burst;
        logic [DW-1:0] data;
    } cmd_exp_t;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } rsp_exp_t;

    cmd_exp_t cmd_q[$];
    rsp_exp_t rsp_q[$];
    cmd_exp_t mon_c;
    rsp_exp_t mon_r;
    int checks = 0;
    int errors = 0;

    fifo_cmd_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_cmd_valid(s0_cmd_valid), .s0_cmd_ready(s0_cmd_ready), .s0_cmd_type(s0_cmd_type),
        .s0_cmd_addr(s0_cmd_addr), .s0_cmd_burst_cnt(s0_cmd_burst_cnt),
        .s0_cmd_wt_data(s0_cmd_wt_data), .s0_cmd_wt_mask(s0_cmd_wt_mask),
        .s0_rsp_valid(s0_rsp_valid), .s0_rsp_ready(s0_rsp_ready), .s0_rsp_data(s0_rsp_data),
        .s1_cmd_valid(s1_cmd_valid), .s1_cmd_ready(s1_cmd_ready), .s1_cmd_type(s1_cmd_type),
        .s1_cmd_addr(s1_cmd_addr), .s1_cmd_burst_cnt(s1_cmd_burst_cnt),
        .s1_cmd_wt_data(s1_cmd_wt_data), .s1_cmd_wt_mask(s1_cmd_wt_mask),
        .s1_rsp_valid(s1_rsp_valid), .s1_rsp_ready(s1_rsp_ready), .s1_rsp_data(s1_rsp_data),
        .fifo_cmd_valid(fifo_cmd_valid), .fifo_cmd_ready(fifo_cmd_ready),
        .fifo_cmd_type(fifo_cmd_type), .fifo_cmd_addr(fifo_cmd_addr),
        .fifo_cmd_burst_cnt(fifo_cmd_burst_cnt), .fifo_cmd_wt_data(fifo_cmd_wt_data),
        .fifo_cmd_wt_mask(fifo_cmd_wt_mask),
        .fifo_rsp_valid(fifo_rsp_valid), .fifo_rsp_ready(fifo_rsp_ready),
        .fifo_rsp_data(fifo_rsp_data), .err_unexp_rsp(err_unexp_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] mask_of(input logic [DW-1:0] d);
        return ~d[MW-1:0];
    endfunction

    task automatic exp_cmd(input logic port, input logic typ, input logic [AW-1:0] addr,
                           input logic [5:0] burst, input logic [DW-1:0] data);
        cmd_q.push_back('{port: port, typ: typ, addr: addr, burst: burst, data: data});
    endtask

    task automatic exp_rsp(input logic port, input logic [DW-1:0] data);
        rsp_q.push_back('{port: port, data: data});
    endtask

    task automatic send(input logic port, input logic typ, input logic [AW-1:0] addr,
                        input logic [5:0] burst, input logic [DW-1:0] data);
        bit acc = 1'b0;
        if (port) begin
            s1_cmd_type = typ; s1_cmd_addr = addr; s1_cmd_burst_cnt = burst;
            s1_cmd_wt_data = data; s1_cmd_wt_mask = mask_of(data); s1_cmd_valid = 1'b1;
        end else begin
            s0_cmd_type = typ; s0_cmd_addr = addr; s0_cmd_burst_cnt = burst;
            s0_cmd_wt_data = data; s0_cmd_wt_mask = mask_of(data); s0_cmd_valid = 1'b1;
        end
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            acc = port ? (s1_cmd_valid && s1_cmd_ready) : (s0_cmd_valid && s0_cmd_ready);
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 0, 1);
        if (port) s1_cmd_valid = 1'b0;
        else      s0_cmd_valid = 1'b0;
    endtask

    task automatic rsp_beat(input logic [DW-1:0] data);
        bit hs = 1'b0;
        fifo_rsp_valid = 1'b1;
        fifo_rsp_data  = data;
        for (int i = 0; i < 300 && !hs; i++) begin
            @(negedge clk);
            hs = fifo_rsp_valid && fifo_rsp_ready;
            @(posedge clk);
            #1;
        end
        if (!hs) chk("rsp_timeout", 0, 1);
        fifo_rsp_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && fifo_cmd_valid && fifo_cmd_ready) begin
            if (cmd_q.size() == 0) begin
                chk("cmd_unexpected", 1, 0);
            end else begin
                mon_c = cmd_q.pop_front();
                chk("cmd_s1_ready", s1_cmd_ready, mon_c.port);
                chk("cmd_s0_ready", s0_cmd_ready, !mon_c.port);
                chk("cmd_type", fifo_cmd_type, mon_c.typ);
                chk("cmd_addr", fifo_cmd_addr, mon_c.addr);
                chk("cmd_burst", fifo_cmd_burst_cnt, mon_c.burst);
                chk("cmd_data", fifo_cmd_wt_data, mon_c.data);
                chk("cmd_mask", fifo_cmd_wt_mask, mask_of(mon_c.data));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ((s0_rsp_valid && s0_rsp_ready) || (s1_rsp_valid && s1_rsp_ready))) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                mon_r = rsp_q.pop_front();
                chk("rsp_s1_valid", s1_rsp_valid, mon_r.port);
                chk("rsp_s0_valid", s0_rsp_valid, !mon_r.port);
                chk("rsp_data", mon_r.port ? s1_rsp_data : s0_rsp_data, mon_r.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s0_cmd_valid = 0; s0_cmd_type = 0; s0_cmd_addr = 0; s0_cmd_burst_cnt = 0;
        s0_cmd_wt_data = 0; s0_cmd_wt_mask = 0; s0_rsp_ready = 1;
        s1_cmd_valid = 0; s1_cmd_type = 0; s1_cmd_addr = 0; s1_cmd_burst_cnt = 0;
        s1_cmd_wt_data = 0; s1_cmd_wt_mask = 0; s1_rsp_ready = 1;
        fifo_cmd_ready = 1; fifo_rsp_valid = 0; fifo_rsp_data = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_s0_cmd_ready", s0_cmd_ready, 0);
        chk("rst_s1_cmd_ready", s1_cmd_ready, 0);
        chk("rst_fifo_cmd_valid", fifo_cmd_valid, 0);
        chk("rst_s0_rsp_valid", s0_rsp_valid, 0);
        chk("rst_s1_rsp_valid", s1_rsp_valid, 0);
        chk("rst_fifo_rsp_ready", fifo_rsp_ready, 0);
        chk("rst_err", err_unexp_rsp, 0);
        @(posedge clk);
        #1;

        // Simultaneous reads: port 0 first, then port 1; rsp beats split 4/4.
        exp_cmd(0, CMD_READ, 27'h100, 6'd4, 128'h0);
        exp_cmd(1, CMD_READ, 27'h200, 6'd4, 128'h1);
        fork
            send(0, CMD_READ, 27'h100, 6'd4, 128'h0);
            send(1, CMD_READ, 27'h200, 6'd4, 128'h1);
        join
        for (int k = 0; k < 8; k++) exp_rsp(k >= 4, 128'hA0 + 128'(k));
        for (int k = 0; k < 8; k++) rsp_beat(128'hA0 + 128'(k));

        // Write burst of 3 from port 0 holds off a pending port-1 read.
        exp_cmd(0, CMD_WRITE, 27'h300, 6'd3, 128'h11);
        exp_cmd(0, CMD_WRITE, 27'h301, 6'd3, 128'h12);
        exp_cmd(0, CMD_WRITE, 27'h302, 6'd3, 128'h13);
        exp_cmd(1, CMD_READ, 27'h400, 6'd1, 128'h2);
        fork
            begin
                send(0, CMD_WRITE, 27'h300, 6'd3, 128'h11);
                send(0, CMD_WRITE, 27'h301, 6'd3, 128'h12);
                send(0, CMD_WRITE, 27'h302, 6'd3, 128'h13);
            end
            send(1, CMD_READ, 27'h400, 6'd1, 128'h2);
        join
        exp_rsp(1, 128'hB0);
        rsp_beat(128'hB0);

        // Stalled controller: grant stays with the first presented port.
        fifo_cmd_ready = 1'b0;
        exp_cmd(1, CMD_READ, 27'h500, 6'd1, 128'h3);
        exp_cmd(0, CMD_READ, 27'h600, 6'd1, 128'h4);
        fork
            send(1, CMD_READ, 27'h500, 6'd1, 128'h3);
            begin
                repeat (2) @(posedge clk);
                #1;
                send(0, CMD_READ, 27'h600, 6'd1, 128'h4);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("hold_valid", fifo_cmd_valid, 1);
                    chk("hold_addr", fifo_cmd_addr, 27'h500);
                    chk("hold_s0_ready", s0_cmd_ready, 0);
                end
                @(posedge clk);
                #1 fifo_cmd_ready = 1'b1;
            end
        join
        exp_rsp(1, 128'hC0);
        exp_rsp(0, 128'hC1);
        rsp_beat(128'hC0);
        rsp_beat(128'hC1);

        // Fill the tag FIFO; a 5th read waits, a write still passes, first pop frees it.
        for (int i = 0; i < 4; i++) begin
            exp_cmd(i[0], CMD_READ, 27'h700 + 27'(i), 6'd1, 128'h5);
            send(i[0], CMD_READ, 27'h700 + 27'(i), 6'd1, 128'h5);
        end
        exp_cmd(1, CMD_WRITE, 27'h800, 6'd1, 128'h55);
        exp_cmd(0, CMD_READ, 27'h710, 6'd1, 128'h6);
        fork
            send(0, CMD_READ, 27'h710, 6'd1, 128'h6);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("full_blocks_valid", fifo_cmd_valid, 0);
                    chk("full_blocks_ready", s0_cmd_ready, 0);
                end
                @(posedge clk);
                #1;
                send(1, CMD_WRITE, 27'h800, 6'd1, 128'h55);
                @(negedge clk);
                chk("full_still_blocked", fifo_cmd_valid, 0);
                @(posedge clk);
                #1;
                exp_rsp(0, 128'hD0);
                rsp_beat(128'hD0);
            end
        join
        exp_rsp(1, 128'hD1);
        exp_rsp(0, 128'hD2);
        exp_rsp(1, 128'hD3);
        exp_rsp(0, 128'hD4);
        for (int k = 1; k < 5; k++) rsp_beat(128'hD0 + 128'(k));

        // burst_cnt 0 means 64 rsp beats; port 0 back-pressure stalls the controller.
        exp_cmd(0, CMD_READ, 27'h900, 6'd0, 128'h7);
        send(0, CMD_READ, 27'h900, 6'd0, 128'h7);
        for (int k = 0; k < 64; k++) exp_rsp(0, 128'h1000 + 128'(k));
        for (int k = 0; k < 64; k++) begin
            if (k == 10) begin
                s0_rsp_ready   = 1'b0;
                fifo_rsp_valid = 1'b1;
                fifo_rsp_data  = 128'h1000 + 128'(k);
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_fifo_rsp_ready", fifo_rsp_ready, 0);
                    chk("stall_s0_rsp_valid", s0_rsp_valid, 1);
                    @(posedge clk);
                    #1;
                end
                s0_rsp_ready = 1'b1;
            end
            rsp_beat(128'h1000 + 128'(k));
        end
        @(negedge clk);
        chk("no_err_after_64", err_unexp_rsp, 0);
        @(posedge clk);
        #1;

        // Unexpected beat with no tag outstanding is drained and flagged sticky.
        fifo_rsp_valid = 1'b1;
        fifo_rsp_data  = 128'hDEAD;
        @(negedge clk);
        chk("drain_ready", fifo_rsp_ready, 1);
        chk("drain_s0_valid", s0_rsp_valid, 0);
        chk("drain_s1_valid", s1_rsp_valid, 0);
        @(posedge clk);
        #1 fifo_rsp_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("err_sticky", err_unexp_rsp, 1);
        @(posedge clk);
        #1;

        // Reset in the middle of an 8-beat write burst.
        for (int i = 0; i < 3; i++) begin
            exp_cmd(0, CMD_WRITE, 27'hA00 + 27'(i), 6'd8, 128'h20 + 128'(i));
            send(0, CMD_WRITE, 27'hA00 + 27'(i), 6'd8, 128'h20 + 128'(i));
        end
        fifo_cmd_ready = 1'b0;
        s0_cmd_valid   = 1'b1;
        rst            = 1'b1;
        @(negedge clk);
        chk("rst_burst_fifo_valid", fifo_cmd_valid, 0);
        chk("rst_burst_s0_ready", s0_cmd_ready, 0);
        chk("rst_burst_s1_ready", s1_cmd_ready, 0);
        chk("rst_burst_rsp_ready", fifo_rsp_ready, 0);
        chk("rst_burst_err", err_unexp_rsp, 0);
        s0_cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst            = 1'b0;
        fifo_cmd_ready = 1'b1;
        exp_cmd(1, CMD_READ, 27'hB00, 6'd2, 128'h8);
        send(1, CMD_READ, 27'hB00, 6'd2, 128'h8);
        exp_rsp(1, 128'hE0);
        exp_rsp(1, 128'hE1);
        rsp_beat(128'hE0);
        rsp_beat(128'hE1);
        @(negedge clk);
        chk("post_rst_err", err_unexp_rsp, 0);
        chk("cmd_queue_empty", cmd_q.size(), 0);
        chk("rsp_queue_empty", rsp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
